trigger_window_ctrl: RTL
========================

// Module: trigger_window_ctrl
// PURPOSE
// - Downstream of the thresholder top: consumes the global trigger decision and first-trigger
//   timestamp, waits out the post-trigger window, then freezes the DRAM ring-buffer write side
//   and issues one readout request covering [ts-PRE_TRIGGER, ts+POST_TRIGGER_ENDING] (mod 2^16).
// - Sits between the threshold global coordinator and the DRAM controller readout/mask logic.
// PARAMETERS
// - PRE_TRIGGER          16'd5000   samples kept before the trigger timestamp
// - POST_TRIGGER_ENDING  16'd15000  samples recorded after trigger before freezing
// - HOLDOFF_CYCLES       16'd64     clk cycles of dead time after readout completes
// - CNT_WIDTH            16         width of the statistics counters
// PORTS
// - clk               in   1          single clock domain
// - rst_n             in   1          asynchronous reset, active low
// - sample_valid      in   1          one sample written to DRAM this cycle
// - trig_valid        in   1          threshold_decision_to_DRAM_ctrl (level; may stay high)
// - trig_time_stamp   in   16         triggering_time_stamp, valid when trig_valid=1
// - rd_req_valid      out  1          readout request valid
// - rd_req_ready      in   1          DRAM controller accepts request
// - rd_start_addr     out  16         window start sample index
// - rd_end_addr       out  16         window end sample index (inclusive)
// - rd_done           in   1          one-cycle pulse: readout of window finished
// - freeze_write      out  1          stop overwriting ring buffer
// - busy              out  1          1 in any state except IDLE
// - trig_accepted_cnt out  CNT_WIDTH  triggers accepted (saturating)
// - trig_dropped_cnt  out  CNT_WIDTH  triggers seen while busy (saturating)
// BEHAVIOUR
// - Async reset, active-low: state=IDLE, all outputs 0, addrs 0, counters 0, trig edge reg 0.
// - Trigger event = trig_valid & ~trig_valid_q (rising edge, registered prev); levels ignored.
// - States: IDLE, POST, REQ, READ, HOLD. All outputs registered.
// - IDLE: on event in cycle N -> cycle N+1: state POST, busy=1,
//   rd_start_addr=ts-PRE_TRIGGER, rd_end_addr=ts+POST_TRIGGER_ENDING (16-bit wrap, no sat),
//   post counter=POST_TRIGGER_ENDING, trig_accepted_cnt+1. If POST_TRIGGER_ENDING=0, go to REQ
//   instead of POST.
// - POST: counter decrements on each sample_valid; when it decrements to 0 -> REQ next cycle.
//   No sample_valid -> stays in POST indefinitely.
// - REQ: rd_req_valid=1, freeze_write=1; addrs stable until handshake. Cycle with
//   rd_req_valid&rd_req_ready -> READ next cycle, rd_req_valid drops to 0.
// - READ: freeze_write=1; rd_done -> HOLD next cycle, freeze_write=0, hold counter=HOLDOFF_CYCLES.
//   rd_done outside READ (incl. same cycle as handshake) ignored.
// - HOLD: counter decrements each clk; at 0 (or HOLDOFF_CYCLES=0) -> IDLE next cycle.
// - Event in any state other than IDLE: trig_dropped_cnt+1, no other effect; window unchanged.
// - Counters saturate at all-ones. Addresses hold last window after return to IDLE.
// - Reset mid-operation: immediate return to reset values; in-flight request abandoned.
// STRUCTURE
// - Shared package: state enum encoding, default PRE/POST/HOLDOFF constants
//   (POST_TRIGGER_ENDING shared with the threshold global coordinator).
// - One natural sub-module: sat_counter (CNT_WIDTH, inc, out) used twice for statistics.
// - FSM + two down-counters + address adders inline in this module.
// TESTING
// - Basic: ts=16'd20000, PRE=5000, POST=10, sample_valid=1 -> start=15000, end=20010,
//   rd_req_valid 11 cycles after event cycle +1; ready=1 -> READ; rd_done -> HOLD 64 cycles -> IDLE.
// - Wrap: ts=16'd100 -> start=16'd60636; ts=16'd60000, POST=15000 -> end=16'd9464.
// - Backpressure: rd_req_ready low 20 cycles -> rd_req_valid, addrs, freeze_write stable; then
//   ready pulse -> valid low next cycle.
// - Level/drop: trig_valid held high 1000 cycles -> accepted=1, dropped=0; second edge
//   during POST -> dropped=1, addrs unchanged; edge during HOLD -> dropped=2.
// - Gapped samples: sample_valid every 3rd cycle, POST=4 -> REQ after 4 strobes (~12 clk).
// - Reset asserted in READ -> all outputs 0 immediately; next edge after release accepted normally.

Source files
------------

// File: rtl/trigger_window_ctrl_pkg.sv
// Shared types and default window constants for the trigger window controller.
package trigger_window_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POST = 3'd1,
      ST_REQ  = 3'd2,
      ST_READ = 3'd3,
      ST_HOLD = 3'd4
   } twc_state_e;

   // POST_TRIGGER_ENDING_DEF is also used by the threshold global coordinator.
   localparam logic [15:0] PRE_TRIGGER_DEF         = 16'd5000;
   localparam logic [15:0] POST_TRIGGER_ENDING_DEF = 16'd15000;
   localparam logic [15:0] HOLDOFF_CYCLES_DEF      = 16'd64;
   localparam int          CNT_WIDTH_DEF           = 16;

endpackage

// File: rtl/trigger_window_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module trigger_window_ctrl_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Increment on request unless already saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/trigger_window_ctrl.sv
// Trigger window controller: on a trigger edge, waits out the post-trigger
// window, freezes the ring buffer and issues one readout request.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a trigger rising edge
// POST    | counting post-trigger samples before freezing the buffer
// REQ     | buffer frozen, readout request presented to DRAM controller
// READ    | request accepted, buffer frozen until rd_done
// HOLD    | dead time after readout; edges are counted as dropped
module trigger_window_ctrl
   import trigger_window_ctrl_pkg::*;
#(
   parameter logic [15:0] PRE_TRIGGER         = PRE_TRIGGER_DEF,
   parameter logic [15:0] POST_TRIGGER_ENDING = POST_TRIGGER_ENDING_DEF,
   parameter logic [15:0] HOLDOFF_CYCLES      = HOLDOFF_CYCLES_DEF,
   parameter int          CNT_WIDTH           = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_valid,
   input  logic                 trig_valid,
   input  logic [15:0]          trig_time_stamp,
   output logic                 rd_req_valid,
   input  logic                 rd_req_ready,
   output logic [15:0]          rd_start_addr,
   output logic [15:0]          rd_end_addr,
   input  logic                 rd_done,
   output logic                 freeze_write,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] trig_accepted_cnt,
   output logic [CNT_WIDTH-1:0] trig_dropped_cnt
);

   twc_state_e  state_q;
   twc_state_e  state_nxt;
   logic        trig_valid_q;
   logic        trig_evt;
   logic        trig_accept;
   logic        trig_drop;
   logic [15:0] post_cnt_q;
   logic [15:0] hold_cnt_q;

   assign trig_evt    = trig_valid & ~trig_valid_q;
   assign trig_accept = trig_evt & (state_q == ST_IDLE);
   assign trig_drop   = trig_evt & (state_q != ST_IDLE);

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trig_evt) begin
               state_nxt = (POST_TRIGGER_ENDING == 16'd0) ? ST_REQ : ST_POST;
            end
         end
         ST_POST: begin
            if (sample_valid && (post_cnt_q <= 16'd1)) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (rd_req_valid && rd_req_ready) begin
               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (rd_done) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q <= 16'd1) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         trig_valid_q <= 1'b0;
         busy         <= 1'b0;
         rd_req_valid <= 1'b0;
         freeze_write <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         trig_valid_q <= trig_valid;
         busy         <= (state_nxt != ST_IDLE);
         rd_req_valid <= (state_nxt == ST_REQ);
         freeze_write <= (state_nxt == ST_REQ) || (state_nxt == ST_READ);
      end
   end

   // Window addresses latch only on an accepted trigger; 16-bit wrap is intended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_start_addr <= 16'd0;
         rd_end_addr   <= 16'd0;
      end else if (trig_accept) begin
         rd_start_addr <= trig_time_stamp - PRE_TRIGGER;
         rd_end_addr   <= trig_time_stamp + POST_TRIGGER_ENDING;
      end
   end

   // Post-trigger sample down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_cnt_q <= 16'd0;
      end else if (trig_accept) begin
         post_cnt_q <= POST_TRIGGER_ENDING;
      end else if ((state_q == ST_POST) && sample_valid && (post_cnt_q != 16'd0)) begin
         post_cnt_q <= post_cnt_q - 16'd1;
      end
   end

   // Holdoff down-counter, loaded when readout completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= 16'd0;
      end else if ((state_q == ST_READ) && rd_done) begin
         hold_cnt_q <= HOLDOFF_CYCLES;
      end else if ((state_q == ST_HOLD) && (hold_cnt_q != 16'd0)) begin
         hold_cnt_q <= hold_cnt_q - 16'd1;
      end
   end

   trigger_window_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_acc_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (trig_accept),
      .cnt   (trig_accepted_cnt)
   );

   trigger_window_ctrl_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (trig_drop),
      .cnt   (trig_dropped_cnt)
   );

endmodule
